// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the receive and transmit FCS stages.
// Reflected CRC-32 (IEEE 802.3): polynomial 0xEDB88320, init 0xFFFFFFFF.
// Running the CRC over a frame plus its own FCS leaves the fixed residue
// 0xDEBB20E3. The 256-entry byte table is built by a constant function at
// elaboration time.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef logic [255:0][31:0] crc32_tbl_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_INFRAME = 1'b1
  } fcs_state_e;

  // Entry i is the CRC of byte i shifted through eight reflected steps.
  function automatic crc32_tbl_t crc32_gen_table();
    crc32_tbl_t  t;
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      t[8'(i)] = c;
    end
    return t;
  endfunction

  localparam crc32_tbl_t CRC32_TBL = crc32_gen_table();

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    return (crc >> 8) ^ CRC32_TBL[crc[7:0] ^ data];
  endfunction

endpackage

// File: rtl/crc32_byte_engine.sv
// Combinational one-byte CRC-32 step, shared by the FCS generator and checker.
// Ports:
//   crc_i  [31:0]  current CRC register
//   data_i [7:0]   byte to absorb
//   crc_o  [31:0]  CRC after absorbing data_i
module crc32_byte_engine
  import crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/crc32_fcs_checker.sv
// Receive-side FCS checker. Consumes a sop/last framed byte stream whose last
// four bytes are the CRC-32 FCS, forwards the payload with the FCS stripped,
// and reports good/bad/runt/abort per frame with saturating counters.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_sop/in_last/in_data  input byte stream
//   out_valid/out_data/out_last      payload stream (1 clk + 4 beats behind)
//   out_ok                           CRC verdict, valid with out_last
//   frame_done/frame_ok              one pulse per terminated frame + verdict
//   frame_runt/frame_abort           termination reason flags
//   good_cnt/bad_cnt                 saturating frame counters
module crc32_fcs_checker
  import crc32_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int FCS_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_last,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_ok,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             frame_runt,
  output logic             frame_abort,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  if (FCS_BYTES != 4) begin : g_fcs_bytes_check
    $error("crc32_fcs_checker: FCS_BYTES must be 4");
  end

  // Byte count saturates one past the FCS length: that is all the FSM needs
  // to know (delay line full, frame long enough to carry payload).
  localparam logic [2:0] CNT_FULL = 3'(FCS_BYTES);
  localparam logic [2:0] CNT_SAT  = 3'(FCS_BYTES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fcs_state_e                 state_q, state_d;
  logic [31:0]                crc_q, crc_d, crc_base, crc_next;
  logic [2:0]                 cnt_q, cnt_d;
  logic [FCS_BYTES-1:0][7:0]  dl_q;
  logic                       dl_load, dl_shift;
  logic                       have_fcs, crc_good;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_ok_q, out_ok_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_runt_q, frame_runt_d;
  logic             frame_abort_q, frame_abort_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  // A sop byte always starts from the init value, even when it cuts a frame.
  assign crc_base = (state_q == ST_IDLE || in_sop) ? CRC32_INIT : crc_q;

  crc32_byte_engine u_engine (
    .crc_i  (crc_base),
    .data_i (in_data),
    .crc_o  (crc_next)
  );

  assign have_fcs = (cnt_q >= CNT_FULL);
  assign crc_good = (crc_next == CRC32_RESIDUE);

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    cnt_d         = cnt_q;
    dl_load       = 1'b0;
    dl_shift      = 1'b0;
    out_valid_d   = 1'b0;
    out_data_d    = 8'h00;
    out_last_d    = 1'b0;
    out_ok_d      = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = 1'b0;
    frame_runt_d  = 1'b0;
    frame_abort_d = 1'b0;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;

    if (in_valid) begin
      if (in_sop) begin
        dl_load = 1'b1;
        // sop inside a frame aborts it; sop&last is a 1-byte runt. A runt
        // that also cuts an open frame is reported once, as a runt.
        if (state_q == ST_INFRAME || in_last) begin
          frame_done_d  = 1'b1;
          frame_runt_d  = in_last;
          frame_abort_d = ~in_last;
          bad_cnt_d     = sat_inc(bad_cnt_q);
        end
        if (in_last) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          crc_d   = CRC32_INIT;
        end else begin
          state_d = ST_INFRAME;
          cnt_d   = 3'd1;
          crc_d   = crc_next;
        end
      end else if (state_q == ST_INFRAME) begin
        dl_shift = 1'b1;
        crc_d    = crc_next;
        cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 3'd1;
        // Once four bytes are buffered, each new byte pushes out a payload byte.
        if (have_fcs) begin
          out_valid_d = 1'b1;
          out_data_d  = dl_q[FCS_BYTES-1];
        end
        if (in_last) begin
          state_d      = ST_IDLE;
          cnt_d        = 3'd0;
          crc_d        = CRC32_INIT;
          frame_done_d = 1'b1;
          if (have_fcs) begin
            out_last_d = 1'b1;
            out_ok_d   = crc_good;
            frame_ok_d = crc_good;
            if (crc_good) good_cnt_d = sat_inc(good_cnt_q);
            else          bad_cnt_d  = sat_inc(bad_cnt_q);
          end else begin
            frame_runt_d = 1'b1;
            bad_cnt_d    = sat_inc(bad_cnt_q);
          end
        end
      end
      // in_valid without sop while idle: byte is dropped silently.
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      crc_q         <= CRC32_INIT;
      cnt_q         <= 3'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_last_q    <= 1'b0;
      out_ok_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_runt_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_ok_q      <= out_ok_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      frame_runt_q  <= frame_runt_d;
      frame_abort_q <= frame_abort_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
    end
  end

  // Delay line holds data only; which entries are live is given by cnt_q,
  // so clearing cnt_q on reset or frame end is what empties it.
  always_ff @(posedge clk) begin
    if (dl_load) begin
      dl_q[0] <= in_data;
    end else if (dl_shift) begin
      dl_q <= {dl_q[FCS_BYTES-2:0], in_data};
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_ok      = out_ok_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_runt  = frame_runt_q;
  assign frame_abort = frame_abort_q;
  assign good_cnt    = good_cnt_q;
  assign bad_cnt     = bad_cnt_q;

endmodule

// File: doc/crc32_fcs_checker.md
Name: crc32_fcs_checker

Overview:
- Receive-side stage that consumes a byte stream framed by sop/last and carrying a trailing 4-byte CRC-32 FCS.
- Strips the FCS and forwards payload bytes downstream.
- Checks each frame with the table-driven reflected CRC-32 engine (poly 0xEDB88320, init 0xFFFFFFFF) and reports good/bad/runt per frame.
- Keeps saturating good/bad frame counters for status readout.

Parameters:
- CNT_W, 16, width of good/bad frame counters.
- FCS_BYTES, 4, FCS length in bytes; fixed at 4, any other value is rejected by elaboration assertion.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_sop  in  1  first byte of frame; qualified by in_valid.
- in_last  in  1  last byte of frame (last FCS byte); qualified by in_valid.
- in_data  in  8  input byte.
- out_valid  out  1  payload byte valid.
- out_data  out  8  payload byte.
- out_last  out  1  last payload byte of frame.
- out_ok  out  1  with out_last: 1 = CRC good; else 0.
- frame_done  out  1  one-cycle pulse per terminated frame (good, bad, runt or abort).
- frame_ok  out  1  status of the frame terminated by frame_done.
- frame_runt  out  1  with frame_done: frame was shorter than 5 bytes.
- frame_abort  out  1  with frame_done: frame cut by new sop.
- good_cnt  out  CNT_W  saturating count of good frames.
- bad_cnt  out  CNT_W  saturating count of bad, runt and aborted frames.

Behaviour:
- Reset (async): all outputs 0, counters 0, CRC register 0xFFFFFFFF, byte count 0, delay line empty, state IDLE.
- States:
  - IDLE: in_valid & in_sop -> INFRAME. In the same cycle, CRC = update(0xFFFFFFFF, byte), count = 1, and the byte enters the delay line.
  - IDLE: in_valid without sop -> byte dropped, no status.
  - INFRAME: each in_valid beat updates CRC, increments count (saturates at 5), and shifts the 4-entry delay line.
- Payload emission:
  - When the delay line already holds 4 bytes, the displaced (oldest) byte is registered to out_data with out_valid=1 one cycle after the beat. Latency is 1 clock plus 4 input beats.
  - out_valid is 0 in all other cycles. No backpressure; gaps in in_valid pass through as gaps.
- in_last beat, count >= 4 before the beat:
  - Next cycle: out_valid=1, out_data=displaced byte, out_last=1.
  - out_ok = (CRC after this byte == residue 0xDEBB20E3).
  - frame_done=1, frame_ok=out_ok, frame_runt=0, frame_abort=0.
  - One counter increments. State -> IDLE, delay line flushed, CRC re-initialised.
- in_last with total length <= 4 (runt):
  - No payload emitted, out_valid=0.
  - Next cycle: frame_done=1, frame_runt=1, frame_ok=0. bad_cnt++. State -> IDLE.
- in_sop while INFRAME without in_last (abort):
  - Next cycle: frame_done=1, frame_abort=1, frame_ok=0. bad_cnt++.
  - The buffered bytes of the old frame are discarded. No out_last is ever issued for it; downstream uses frame_abort to drop it.
  - The new sop byte starts a fresh frame in the same cycle: CRC init, count=1.
- in_sop & in_last on the same beat: a 1-byte runt, reported as runt.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- CRC step (reflected): crc_next = (crc >> 8) ^ TBL[crc[7:0] ^ data]. The table is generated by a constant function, not hand-listed.
- Reset asserted mid-frame: everything returns to reset values immediately. A partial frame is lost with no status pulse.

Decomposition:
- Package crc32_pkg holds:
  - CRC32_POLY_REFL=0xEDB88320, CRC32_INIT=0xFFFFFFFF, CRC32_RESIDUE=0xDEBB20E3.
  - Function crc32_byte(crc, data) returning the next CRC.
  - Constant table-generation function.
- Sub-module crc32_byte_engine: combinational next-CRC from (crc, data) using the package function. It is shared with the existing CRC generator stage.
- The delay line, FSM and counters stay in crc32_fcs_checker.

Test Plan:
- Good frame: "123456789" (0x31..0x39) then FCS 0x26,0x39,0xF4,0xCB, contiguous.
  - Expect 9 out bytes 0x31..0x39, out_last on 0x39, out_ok=1, frame_ok=1, good_cnt=1.
- Same frame with in_data bit 0 of byte 3 flipped (0x32).
  - Expect payload 0x31,0x32,0x32,..., out_ok=0, frame_done with frame_ok=0, bad_cnt=1.
- Good frame with in_valid deasserted every other cycle.
  - Expect identical payload and out_ok=1; out_valid gaps track input gaps.
- Runts: frames of 1 byte (sop&last) and 4 bytes.
  - Expect out_valid never 1, two frame_done pulses with frame_runt=1, bad_cnt=2.
- Abort: 6 bytes of a frame, then sop of the good "123456789" frame.
  - Expect frame_abort pulse, bad_cnt+1, 2 bytes emitted without out_last, then the second frame passes with out_ok=1.
- Reset mid-frame after 3 payload bytes emitted, then the good frame.
  - Expect outputs 0 during reset, no frame_done for the cut frame, then good_cnt=1.
- Counter saturation: with CNT_W=2, send 5 good frames.
  - Expect good_cnt holds at 3.
